// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared constants, ALU opcodes and FSM state type for the ALU op sequencer
package alu_seq_pkg;
    localparam int DATA_W = 4;
    localparam int REG_AW = 3;
    localparam int NREG   = 8;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_GT  = 3'b110;
    localparam logic [2:0] ALU_EQL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_t;
endpackage

// File: rtl/alu_seq_regfile.sv
// rtl/alu_seq_regfile.sv - register file with two operand read ports, debug read port, r0 hardwired to zero
module alu_seq_regfile #(
    parameter int DATA_W = 4,
    parameter int NREG   = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);
    logic [DATA_W-1:0] mem [NREG];

    // r0 is never written, so its storage stays at the cleared value of zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wr_addr != '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign ra_data  = mem[ra_addr];
    assign rb_data  = mem[rb_addr];
    assign dbg_data = mem[dbg_addr];
endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issue stage: command accept, operand fetch, ALU drive, result capture and write-back
module alu_op_sequencer #(
    parameter int DATA_W = 4,
    parameter int NREG   = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_ra,
    input  logic [REG_AW-1:0] cmd_rb,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic              cmd_imm_en,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_s,
    input  logic [DATA_W-1:0] alu_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [REG_AW-1:0] res_rd,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    import alu_seq_pkg::*;

    seq_state_t        state;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic              wb_en;

    assign wb_en = (state == EXEC);

    alu_seq_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (cmd_ra),
        .ra_data  (ra_data),
        .rb_addr  (cmd_rb),
        .rb_data  (rb_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (wb_en),
        .wr_addr  (rd_q),
        .wr_data  (alu_y)
    );

    // Operands are fetched at accept time; the previous write-back has already
    // landed by then, so the registered ALU inputs always see current values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
            rd_q      <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= ALU_ADD;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state     <= EXEC;
                        cmd_ready <= 1'b0;
                        rd_q      <= cmd_rd;
                        alu_a     <= ra_data;
                        alu_b     <= cmd_imm_en ? cmd_imm : rb_data;
                        alu_s     <= cmd_op;
                    end
                end
                EXEC: begin
                    state     <= RESP;
                    res_valid <= 1'b1;
                    res_data  <= alu_y;
                    res_rd    <= rd_q;
                    alu_a     <= '0;
                    alu_b     <= '0;
                    alu_s     <= ALU_ADD;
                end
                RESP: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer with a behavioural ALU alongside
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_ra;
    logic [2:0] cmd_rb;
    logic [2:0] cmd_rd;
    logic       cmd_imm_en;
    logic [3:0] cmd_imm;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_s;
    logic [3:0] alu_y;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic [2:0] res_rd;
    logic [2:0] dbg_addr;
    logic [3:0] dbg_data;

    int tests;
    int failed;
    int cyc;
    int last_acc;
    int acc_gap;

    alu_op_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_ra     (cmd_ra),
        .cmd_rb     (cmd_rb),
        .cmd_rd     (cmd_rd),
        .cmd_imm_en (cmd_imm_en),
        .cmd_imm    (cmd_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .alu_y      (alu_y),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_rd     (res_rd),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always_comb begin
        alu_y = 4'h0;
        case (alu_s)
            ALU_ADD: alu_y = alu_a + alu_b;
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_NOT: alu_y = ~alu_a;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_XOR: alu_y = alu_a ^ alu_b;
            ALU_GT:  alu_y = ($signed(alu_a) > $signed(alu_b)) ? 4'h1 : 4'h0;
            ALU_EQL: alu_y = (alu_a == alu_b) ? 4'h1 : 4'h0;
            default: alu_y = 4'h0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                          input logic [2:0] rd, input logic ie, input logic [3:0] imm,
                          input logic [3:0] exp);
        int n;
        cmd_op     = op;
        cmd_ra     = ra;
        cmd_rb     = rb;
        cmd_rd     = rd;
        cmd_imm_en = ie;
        cmd_imm    = imm;
        cmd_valid  = 1'b1;
        dbg_addr   = rd;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_wait", 8'(n < 20), 8'h1);
        @(posedge clk); #1;
        acc_gap  = cyc - last_acc;
        last_acc = cyc;
        cmd_valid = 1'b0;
        chk("exec_cmd_ready", 8'(cmd_ready), 8'h0);
        chk("exec_alu_s", 8'(alu_s), 8'(op));
        chk("exec_res_valid", 8'(res_valid), 8'h0);
        @(posedge clk); #1;
        chk("resp_valid", 8'(res_valid), 8'h1);
        chk("resp_data", 8'(res_data), 8'(exp));
        chk("resp_rd", 8'(res_rd), 8'(rd));
        chk("resp_dbg", 8'(dbg_data), (rd == 3'd0) ? 8'h0 : 8'(exp));
        chk("resp_cmd_ready", 8'(cmd_ready), 8'h0);
        if (res_ready) begin
            @(posedge clk); #1;
            chk("idle_res_valid", 8'(res_valid), 8'h0);
            chk("idle_cmd_ready", 8'(cmd_ready), 8'h1);
        end
    endtask

    initial begin
        tests = 0; failed = 0; last_acc = 0; acc_gap = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b1;
        cmd_op = 3'b0; cmd_ra = 3'b0; cmd_rb = 3'b0; cmd_rd = 3'b0;
        cmd_imm_en = 1'b0; cmd_imm = 4'h0; dbg_addr = 3'd0;

        // reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 8'(cmd_ready), 8'h1);
        chk("rst_res_valid", 8'(res_valid), 8'h0);
        chk("rst_res_data", 8'(res_data), 8'h0);
        chk("rst_res_rd", 8'(res_rd), 8'h0);
        chk("rst_alu_a", 8'(alu_a), 8'h0);
        chk("rst_alu_b", 8'(alu_b), 8'h0);
        chk("rst_alu_s", 8'(alu_s), 8'h0);
        rst_n = 1'b1;

        // load and register add
        run_op(ALU_ADD, 3'd0, 3'd0, 3'd1, 1'b1, 4'h3, 4'h3);
        run_op(ALU_ADD, 3'd0, 3'd0, 3'd2, 1'b1, 4'h4, 4'h4);
        run_op(ALU_ADD, 3'd1, 3'd2, 3'd3, 1'b0, 4'h0, 4'h7);

        // signed ops
        run_op(ALU_ADD, 3'd0, 3'd0, 3'd1, 1'b1, 4'h2, 4'h2);
        run_op(ALU_ADD, 3'd0, 3'd0, 3'd2, 1'b1, 4'h5, 4'h5);
        run_op(ALU_SUB, 3'd1, 3'd2, 3'd4, 1'b0, 4'h0, 4'hD);
        run_op(ALU_GT,  3'd4, 3'd1, 3'd5, 1'b0, 4'h0, 4'h0);
        run_op(ALU_EQL, 3'd1, 3'd1, 3'd6, 1'b0, 4'h0, 4'h1);

        // wrap and r0 discard
        run_op(ALU_ADD, 3'd0, 3'd0, 3'd1, 1'b1, 4'h7, 4'h7);
        run_op(ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 4'h1, 4'h8);
        run_op(ALU_ADD, 3'd1, 3'd0, 3'd7, 1'b1, 4'h1, 4'h8);

        // backpressure: r2 = r7 + 1 held in RESP, pending xor r3 = r1 ^ r7
        res_ready = 1'b0;
        run_op(ALU_ADD, 3'd7, 3'd0, 3'd2, 1'b1, 4'h1, 4'h9);
        cmd_op = ALU_XOR; cmd_ra = 3'd1; cmd_rb = 3'd7; cmd_rd = 3'd3;
        cmd_imm_en = 1'b0; cmd_imm = 4'h0; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_res_valid", 8'(res_valid), 8'h1);
            chk("bp_res_data", 8'(res_data), 8'h9);
            chk("bp_cmd_ready", 8'(cmd_ready), 8'h0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 8'(res_valid), 8'h0);
        chk("bp_release_ready", 8'(cmd_ready), 8'h1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("bp_accept_ready", 8'(cmd_ready), 8'h0);
        chk("bp_accept_alu_s", 8'(alu_s), 8'(ALU_XOR));
        @(posedge clk); #1;
        chk("bp_xor_data", 8'(res_data), 8'hF);
        chk("bp_xor_rd", 8'(res_rd), 8'h3);
        @(posedge clk); #1;

        // reset during EXEC of add r3 = r1 + r2
        cmd_op = ALU_ADD; cmd_ra = 3'd1; cmd_rb = 3'd2; cmd_rd = 3'd3;
        cmd_imm_en = 1'b0; cmd_valid = 1'b1; dbg_addr = 3'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("mid_exec_alu_a", 8'(alu_a), 8'h7);
        chk("mid_exec_alu_b", 8'(alu_b), 8'h9);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_res_valid", 8'(res_valid), 8'h0);
        chk("mid_rst_cmd_ready", 8'(cmd_ready), 8'h1);
        chk("mid_rst_dbg3", 8'(dbg_data), 8'h0);
        chk("mid_rst_alu_s", 8'(alu_s), 8'h0);
        chk("mid_rst_alu_a", 8'(alu_a), 8'h0);
        @(posedge clk); #1;
        chk("mid_rst_dbg3_after", 8'(dbg_data), 8'h0);
        dbg_addr = 3'd7;
        #1;
        chk("mid_rst_dbg7", 8'(dbg_data), 8'h0);

        // logic ops back to back
        run_op(ALU_ADD, 3'd0, 3'd0, 3'd1, 1'b1, 4'hC, 4'hC);
        run_op(ALU_ADD, 3'd0, 3'd0, 3'd2, 1'b1, 4'hA, 4'hA);
        chk("gap_load", 8'(acc_gap), 8'd3);
        run_op(ALU_AND, 3'd1, 3'd2, 3'd3, 1'b0, 4'h0, 4'h8);
        chk("gap_and", 8'(acc_gap), 8'd3);
        run_op(ALU_OR,  3'd1, 3'd2, 3'd4, 1'b0, 4'h0, 4'hE);
        chk("gap_or", 8'(acc_gap), 8'd3);
        run_op(ALU_XOR, 3'd1, 3'd2, 3'd5, 1'b0, 4'h0, 4'h6);
        chk("gap_xor", 8'(acc_gap), 8'd3);
        run_op(ALU_NOT, 3'd1, 3'd2, 3'd6, 1'b0, 4'h0, 4'h3);
        chk("gap_not", 8'(acc_gap), 8'd3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
